apb_wait_slave: RTL and testbench
=================================

Name: apb_wait_slave

Overview:
APB completer that sits directly downstream of the APB master bridge. The bridge drives this block's PSEL, PENABLE, PWRITE, PADDR and PWDATA; this block returns PRDATA, PREADY and PSLVERR to the bridge's read mux. It contains a byte-wide register file with a programmable number of wait states and error signalling. Two instances replace the fixed zero-wait slaves on the PSEL1/PSEL2 branches.

Parameters:
DEPTH, 64, number of byte locations; legal addresses are 0..DEPTH-1; DEPTH must be ≤ 256.
WAIT_CYCLES, 2, number of access-phase cycles with PREADY low before completion; range 0..15.
ID_VAL, 8'hA5, constant returned by reads of address 0.

Ports:
PCLK  input  1  clock; all state updates on the rising edge.
PRESETn  input  1  reset, asynchronous, active-low.
PSEL  input  1  slave select from the bridge.
PENABLE  input  1  access-phase strobe from the bridge.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  8  byte address (the bridge's PADDR[7:0]).
PWDATA  input  8  write data.
PRDATA  output  8  read data.
PREADY  output  1  transfer-complete indication.
PSLVERR  output  1  transfer error; valid only when PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is PRESETn, asynchronous and active-low; assertion takes effect immediately, independent of PCLK.
- Reset values: state=IDLE, wait counter=0, all memory locations=0, PRDATA=0, PREADY=0, PSLVERR=0.
- State machine states: IDLE, ACCESS.
- IDLE:
  - Leaves IDLE only on a PCLK edge that samples PSEL=1 and PENABLE=0 (setup phase).
  - On that edge: latch PADDR, PWRITE and PWDATA; load counter=WAIT_CYCLES; go to ACCESS.
  - PENABLE=1 seen in IDLE without a preceding setup: ignored; no write, PREADY stays 0.
- ACCESS:
  - PREADY=1 only when state=ACCESS and counter=0. PREADY is decoded from registers, with no combinational path from inputs.
  - PREADY goes high in access-phase cycle WAIT_CYCLES+1. With WAIT_CYCLES=0, it is high in the first cycle after setup.
  - While counter≠0 and PSEL=1, decrement the counter each edge.
  - Completion edge (PSEL=1, PENABLE=1, PREADY=1):
    - write: commit the latched data if there is no error;
    - read: nothing is committed;
    - then return to IDLE.
  - PSEL=0 sampled in ACCESS before completion: abort, go to IDLE, no write, no error flagged.
  - Changes on PADDR, PWRITE or PWDATA during ACCESS are ignored; the latched copies are used.
- Back-to-back transfers: after completion the next edge is in IDLE. A new setup (PSEL=1, PENABLE=0) is accepted on the first IDLE edge, giving at least one idle-free turnaround exactly as APB requires.
- Error rules, evaluated on the latched address and direction:
  - address ≥ DEPTH: PSLVERR=1;
  - write to address 0 (read-only ID): PSLVERR=1;
  - on error, no memory update and PRDATA=0.
- Read data:
  - address 0 returns ID_VAL;
  - addresses 1..DEPTH-1 return the stored byte.
  - Location 0 exists in the address map only as the ID register.
- Output gating:
  - PRDATA carries a value only while PREADY=1; it is 0 otherwise.
  - PSLVERR is 1 only in the PREADY=1 cycle of an erroring transfer.
- Reset mid-transfer: outputs are forced to reset values immediately and any pending write is discarded. The bridge sees PREADY=0.

Test Plan:
1. Write 8'h3C to addr 8'h05 with WAIT_CYCLES=2, then read 8'h05 -> PREADY low for 2 access cycles and high on the 3rd, PSLVERR=0; the read returns PRDATA=8'h3C with PRDATA=0 outside the PREADY cycle.
2. Read addr 8'h00 -> PRDATA=8'hA5, PSLVERR=0. Write 8'hFF to addr 8'h00 -> PSLVERR=1 in the PREADY cycle; a following read of 8'h00 still returns 8'hA5.
3. Write 8'h77 to addr 8'h40 with DEPTH=64 -> PSLVERR=1. Read 8'h40 -> PSLVERR=1, PRDATA=8'h00. Contents of addrs 1..63 are unchanged.
4. Start a write of 8'h11 to addr 8'h07, drop PSEL in the 1st access cycle (WAIT_CYCLES=2) -> no PREADY, return to IDLE; a read of 8'h07 returns its prior value 8'h00.
5. Back-to-back write 8'h01→addr 1, write 8'h02→addr 2, read 1, read 2 with WAIT_CYCLES=0 -> each transfer completes in 2 cycles (setup + access); reads return 8'h01 and 8'h02. Changing PWDATA during an access phase does not alter the stored value.
6. Assert PRESETn low mid-wait during a write of 8'h99 to addr 8'h09 -> PREADY, PRDATA and PSLVERR go to 0 immediately, without waiting for PCLK; after release a read of 8'h09 returns 8'h00.

Source files
------------

// File: rtl/apb_wait_slave.sv
// APB completer with a byte-wide register file, programmable wait states and
// error signalling. Address 0 is a read-only ID register.
module apb_wait_slave #(
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [7:0]  ID_VAL      = 8'hA5
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0] state;
   logic [3:0] cnt;
   logic [7:0] lat_addr;
   logic [7:0] lat_wdata;
   logic       lat_write;
   logic [7:0] mem [1:DEPTH-1];

   logic       ready;
   logic       err;
   logic       commit;
   logic [7:0] rd_word;

   // All outputs decode from registered state only; no input reaches them.
   assign ready  = (state == ACCESS) && (cnt == '0);
   assign err    = ({1'b0, lat_addr} >= DEPTH_W) || (lat_write && (lat_addr == '0));
   assign commit = ready && PSEL && PENABLE && lat_write && !err;

   always_comb begin
      rd_word = '0;
      if (lat_addr == '0)
         rd_word = ID_VAL;
      else if (!err)
         rd_word = mem[lat_addr[AW-1:0]];
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && err;
   assign PRDATA  = (ready && !lat_write && !err) ? rd_word : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  lat_addr  <= PADDR;
                  lat_wdata <= PWDATA;
                  lat_write <= PWRITE;
                  cnt       <= WAIT_LD;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (!PSEL)
                  state <= IDLE;
               else if (cnt != '0)
                  cnt <= cnt - 4'd1;
               else if (PENABLE)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int unsigned i = 1; i < DEPTH; i++)
            mem[AW'(i)] <= '0;
      end else if (commit) begin
         mem[lat_addr[AW-1:0]] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: expected completions are queued as each
// transfer is driven and checked by a monitor when PREADY is seen.
module tb_apb_wait_slave;

   localparam int         DEPTH       = 64;
   localparam int         WAIT_CYCLES = 2;
   localparam logic [7:0] ID_VAL      = 8'hA5;

   logic       PCLK;
   logic       PRESETn;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   typedef struct packed {
      logic [7:0] rd;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model [0:255];
   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;

   apb_wait_slave #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(WAIT_CYCLES),
      .ID_VAL(ID_VAL)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc++;

   // Monitor: completions are popped from the scoreboard, and outside the
   // PREADY cycle the data and error outputs must be held at zero.
   always @(negedge PCLK) begin
      if (PRESETn === 1'b1) begin
         tests++;
         if (PREADY === 1'b1) begin
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_pready: PRDATA=%h PSLVERR=%b, no transfer pending", PRDATA, PSLVERR);
            end else begin
               mon_e = sb.pop_front();
               if (PRDATA !== mon_e.rd || PSLVERR !== mon_e.err) begin
                  fails++;
                  $display("FAIL completion: PRDATA=%h PSLVERR=%b, expected PRDATA=%h PSLVERR=%b",
                           PRDATA, PSLVERR, mon_e.rd, mon_e.err);
               end
            end
         end else if (PREADY !== 1'b0 || PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
            fails++;
            $display("FAIL idle_gating: PREADY=%b PRDATA=%h PSLVERR=%b, expected 0/00/0",
                     PREADY, PRDATA, PSLVERR);
         end
      end
   end

   function automatic exp_t expect_of(input logic w, input logic [7:0] a);
      exp_t e;
      e.err = ({1'b0, a} >= 9'(DEPTH)) || (w && a == 8'h00);
      if (e.err || w)
         e.rd = 8'h00;
      else if (a == 8'h00)
         e.rd = ID_VAL;
      else
         e.rd = model[a];
      return e;
   endfunction

   // Starts at posedge+1, ends at posedge+1 after the completion edge.
   // Address and data are scrambled during the access phase.
   task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, output int waits);
      exp_t e;
      bit   done;
      e = expect_of(w, a);
      sb.push_back(e);
      if (w && !e.err) model[a] = d;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
      @(posedge PCLK) #1;
      PENABLE = 1'b1; PADDR = ~a; PWDATA = ~d;
      waits = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge PCLK);
         if (PREADY === 1'b1) done = 1'b1;
         else begin
            waits++;
            if (waits > 40) begin
               tests++; fails++;
               $display("FAIL timeout: no PREADY after %0d cycles, addr=%h", waits, a);
               sb.delete();
               done = 1'b1;
            end
         end
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic check_waits(input string name, input int waits);
      tests++;
      if (waits != WAIT_CYCLES) begin
         fails++;
         $display("FAIL %s_waits: got %0d wait cycles, expected %0d", name, waits, WAIT_CYCLES);
      end
   endtask

   task automatic test_reset();
      int w;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      #2;
      tests++;
      if (PREADY !== 1'b0 || PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: PREADY=%b PRDATA=%h PSLVERR=%b, expected 0/00/0", PREADY, PRDATA, PSLVERR);
      end
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      @(posedge PCLK) #1;
      xfer(1'b0, 8'h01, 8'h00, w);
      check_waits("reset_read", w);
   endtask

   task automatic test_write_read();
      int w;
      xfer(1'b1, 8'h05, 8'h3C, w);
      check_waits("wr5", w);
      xfer(1'b0, 8'h05, 8'h00, w);
      check_waits("rd5", w);
      xfer(1'b1, 8'h3F, 8'hC3, w);
      xfer(1'b0, 8'h3F, 8'h00, w);
   endtask

   task automatic test_id();
      int w;
      xfer(1'b0, 8'h00, 8'h00, w);
      xfer(1'b1, 8'h00, 8'hFF, w);
      check_waits("id_wr", w);
      xfer(1'b0, 8'h00, 8'h00, w);
   endtask

   task automatic test_out_of_range();
      int w;
      xfer(1'b1, 8'h40, 8'h77, w);
      xfer(1'b0, 8'h40, 8'h00, w);
      xfer(1'b0, 8'hFF, 8'h00, w);
      for (int a = 1; a < DEPTH; a++) xfer(1'b0, 8'(a), 8'h00, w);
   endtask

   task automatic test_abort();
      int w;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h07; PWDATA = 8'h11;
      @(posedge PCLK) #1;
      PSEL = 1'b0;
      repeat (3) begin
         @(negedge PCLK);
         tests++;
         if (PREADY !== 1'b0) begin
            fails++;
            $display("FAIL abort_pready: PREADY=%b, expected 0", PREADY);
         end
      end
      @(posedge PCLK) #1;
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h07; PWDATA = 8'h55;
      repeat (3) begin
         @(negedge PCLK);
         tests++;
         if (PREADY !== 1'b0) begin
            fails++;
            $display("FAIL enable_no_setup: PREADY=%b, expected 0", PREADY);
         end
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK) #1;
      xfer(1'b0, 8'h07, 8'h00, w);
      check_waits("abort_rd", w);
   endtask

   task automatic test_back_to_back();
      int w;
      int c0;
      c0 = cyc;
      xfer(1'b1, 8'h01, 8'h01, w);
      xfer(1'b1, 8'h02, 8'h02, w);
      xfer(1'b0, 8'h01, 8'h00, w);
      xfer(1'b0, 8'h02, 8'h00, w);
      tests++;
      if (cyc - c0 != 4 * (2 + WAIT_CYCLES)) begin
         fails++;
         $display("FAIL b2b_cycles: took %0d cycles, expected %0d", cyc - c0, 4 * (2 + WAIT_CYCLES));
      end
   endtask

   task automatic test_reset_mid();
      int   w;
      exp_t e;
      bit   done;
      // Reset asserted while a read with nonzero data is completing.
      e = expect_of(1'b0, 8'h05);
      sb.push_back(e);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h05;
      @(posedge PCLK) #1;
      PENABLE = 1'b1;
      done = 1'b0;
      w = 0;
      while (!done) begin
         @(negedge PCLK);
         if (PREADY === 1'b1 || w > 40) done = 1'b1;
         else w++;
      end
      #1;
      tests++;
      if (PREADY !== 1'b1 || PRDATA !== 8'h3C) begin
         fails++;
         $display("FAIL pre_reset_read: PREADY=%b PRDATA=%h, expected 1/3c", PREADY, PRDATA);
      end
      #1 PRESETn = 1'b0;
      #1;
      tests++;
      if (PREADY !== 1'b0 || PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_ready: PREADY=%b PRDATA=%h PSLVERR=%b, expected 0/00/0", PREADY, PRDATA, PSLVERR);
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      // Reset asserted mid-wait during a write.
      @(posedge PCLK) #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h09; PWDATA = 8'h99;
      @(posedge PCLK) #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      tests++;
      if (PREADY !== 1'b0 || PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_wait: PREADY=%b PRDATA=%h PSLVERR=%b, expected 0/00/0", PREADY, PRDATA, PSLVERR);
      end
      @(posedge PCLK) #1;
      PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
      @(posedge PCLK) #1;
      xfer(1'b0, 8'h09, 8'h00, w);
      xfer(1'b0, 8'h05, 8'h00, w);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_id();
      test_out_of_range();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge PCLK);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
